// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - instruction fetch responder with wait-state RAM and preload port
// Optional build macro IFETCH_PREFETCH_EN adds a one-entry sequential prefetch buffer.
module inst_fetch_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [63:0]      req_addr,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_inst,
    output logic             rsp_err,
    input  logic             rsp_ready,
    input  logic             ld_ena,
    input  logic [IDX_W-1:0] ld_addr,
    input  logic [31:0]      ld_data
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [7:0]  LAT8     = 8'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic [31:0]      rsp_inst_q, rsp_inst_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      mem_q [DEPTH];

    logic [63:0]      offset;
    logic             in_range;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic             accept;
    logic             rsp_hs;
    logic             pf_hit;
    logic [31:0]      pf_data;

    // Unsigned compare on the full 64-bit offset so addresses below BASE never wrap into range.
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && ((offset >> 2) < 64'(DEPTH));
    assign req_err  = (req_addr[1:0] != 2'b00) || !in_range;
    assign req_idx  = IDX_W'(offset >> 2);

    assign req_ready = rst && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    // Instruction store: not reset, written from the preload port in any state.
    always_ff @(posedge clk) begin
        if (ld_ena) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

`ifdef IFETCH_PREFETCH_EN
    logic             pf_valid_q;
    logic [63:0]      pf_addr_q;
    logic [IDX_W-1:0] pf_idx_q;
    logic [31:0]      pf_data_q;
    logic [63:0]      addr_q;
    logic [IDX_W-1:0] pf_next_idx;
    logic             pf_fill;

    assign pf_hit      = pf_valid_q && (req_addr == pf_addr_q);
    assign pf_data     = pf_data_q;
    assign pf_next_idx = idx_q + IDX_W'(1);
    // DEPTH is a power of two, so the next word is in range unless idx_q is the last word.
    assign pf_fill     = rsp_hs && !rsp_err_q && (idx_q != {IDX_W{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_valid_q <= 1'b0;
            pf_addr_q  <= '0;
            pf_idx_q   <= '0;
            pf_data_q  <= '0;
            addr_q     <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
            end
            if (pf_fill) begin
                pf_valid_q <= !(ld_ena && (ld_addr == pf_next_idx));
                pf_addr_q  <= addr_q + 64'd4;
                pf_idx_q   <= pf_next_idx;
                pf_data_q  <= mem_q[pf_next_idx];
            end else if ((accept && !pf_hit) || (ld_ena && (ld_addr == pf_idx_q))) begin
                pf_valid_q <= 1'b0;
            end
        end
    end
`else
    assign pf_hit  = 1'b0;
    assign pf_data = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        rsp_inst_d = rsp_inst_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d = req_idx;
                    err_d = req_err;
                    if (pf_hit) begin
                        state_d    = RESP;
                        rsp_inst_d = pf_data;
                        rsp_err_d  = 1'b0;
                    end else if (LAT8 == 8'd0) begin
                        state_d    = RESP;
                        rsp_inst_d = req_err ? NOP_INST : mem_q[req_idx];
                        rsp_err_d  = req_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT8;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d    = RESP;
                    rsp_inst_d = err_q ? NOP_INST : mem_q[idx_q];
                    rsp_err_d  = err_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            rsp_inst_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Memory-side responder for the core's instruction fetch interface.
- Accepts one fetch request at a time (64-bit byte address) over a valid/ready handshake.
- Reads a 32-bit instruction from an internal word-addressed instruction RAM after a programmable number of wait states, then returns it over a valid/ready response channel.
- Includes a preload port for image loading and flags misaligned and out-of-range fetches.
- Sits between the fetch logic and the instruction store, and replaces the combinational inst hookup once fetch becomes multi-cycle.

Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address mapped to RAM word 0.
- DEPTH, 1024, number of 32-bit words in the RAM (power of two).
- LATENCY, 2, wait-state cycles between request acceptance and the response (0..255).
- IDX_W, $clog2(DEPTH), word-index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_addr  in  64  fetch byte address.
- req_ready  out  1  responder can accept a request.
- rsp_valid  out  1  response valid.
- rsp_inst  out  32  fetched instruction.
- rsp_err  out  1  fetch fault (misaligned or out of range).
- rsp_ready  in  1  consumer accepts the response.
- ld_ena  in  1  preload write enable.
- ld_addr  in  IDX_W  preload word index.
- ld_data  in  32  preload word.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset on rst.
  - While rst=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_inst=0, rsp_err=0, wait counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-transaction aborts it; the response is dropped and never presented.
- Index: idx = (req_addr - BASE_ADDR) >> 2.
  - In range iff req_addr >= BASE_ADDR and idx < DEPTH (64-bit unsigned compare, no wrap).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch the address and error flags.
  - Go to WAIT with cnt=LATENCY if LATENCY>0; otherwise go to RESP directly.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - When cnt==1, go to RESP.
- Response capture: on the edge entering RESP, rsp_inst/rsp_err are captured.
  - Error when req_addr[1:0]!=0 or out of range: rsp_err=1, rsp_inst=32'h0000_0013 (NOP).
  - Otherwise rsp_err=0, rsp_inst=RAM[idx] as read at that edge.
- Timing: request accepted at edge T gives rsp_valid=1 from T+1+LATENCY.
- RESP:
  - rsp_valid=1; rsp_inst and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge, go to IDLE; rsp_valid drops next cycle.
  - No same-cycle re-accept; minimum issue interval is LATENCY+2 cycles.
- Preload:
  - ld_ena writes RAM[ld_addr]=ld_data at the edge, in any state, including while rst=1 after reset release.
  - A write to the in-flight word on the same edge as capture: capture sees the old data (read-before-write).
- req_addr changing while req_ready=0 is ignored.
- rsp_inst/rsp_err change only on entry to RESP.

Optional Feature:
- Macro: IFETCH_PREFETCH_EN.
- Defined: one-entry sequential prefetch buffer (pf_valid, pf_addr, pf_data).
  - On the RESP handshake of a non-error fetch at address A where A+4 is in range: pf_valid=1, pf_addr=A+4, pf_data=RAM[idx+1] read at that edge.
  - An accepted request with req_addr==pf_addr && pf_valid goes straight to RESP with pf_data and rsp_err=0, so rsp_valid appears at T+1 regardless of LATENCY.
  - Any other accepted request clears pf_valid.
  - An ld_ena write with ld_addr equal to pf_addr's word index clears pf_valid.
  - Reset clears pf_valid.
- Undefined: no buffer; every fetch takes LATENCY wait states.

Test Plan:
1. LATENCY=2: preload word0=32'h0010_0093; request 0x8000_0000 at edge T, rsp_ready=1 -> rsp_valid at T+3, rsp_inst=32'h0010_0093, rsp_err=0, req_ready=1 again at T+4.
2. Request 0x8000_0002 -> rsp_err=1, rsp_inst=32'h0000_0013. Request 0x7FFF_FFFC -> rsp_err=1. Request BASE+4*DEPTH -> rsp_err=1.
3. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_inst and rsp_err stable; req_ready=0; a new req_valid is not accepted until after the handshake.
4. Drive rst=0 during WAIT -> all outputs 0 immediately (asynchronous). After release, rsp_valid stays 0 until a new request; RAM contents intact.
5. LATENCY=0: back-to-back requests 0x8000_0000 then 0x8000_0004 -> each response 1 cycle after acceptance; issue interval 2 cycles.
6. IFETCH_PREFETCH_EN, LATENCY=4:
   - Fetch A=0x8000_0010, then A+4 -> second response at T+1 with RAM[5].
   - Repeat with ld_ena to index 5 between the two fetches -> second response at T+5 with the new data.
